// File: rtl/sub32_seq.sv
// Multi-cycle 32-bit subtractor: diff = a - b - bin, CHUNK bits per clock.
// A registered borrow ripples between slices, one slice per BUSY cycle.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid (and data) until it is accepted.
// in_ready is high only in IDLE and out_valid is high only in DONE.
// The block therefore never accepts new operands in the cycle it hands off a
// result.
module sub32_seq #(
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] diff,
    output logic        bout,
    output logic        neg,
    output logic        zero,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  state_dbg
);

    localparam int NCH = 32 / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     ra;
    logic [31:0]     rb;
    logic            borrow;
    logic [KW-1:0]   k;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sum;
    logic [31:0]      diff_nx;
    logic             borrow_nx;

    assign state_dbg = state;

    // Slice k arithmetic: a + ~b + ~borrow; carry out set means no borrow.
    always_comb begin
        a_sl    = '0;
        b_sl    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (k == KW'(i)) begin
                a_sl = ra[i*CHUNK +: CHUNK];
                b_sl = rb[i*CHUNK +: CHUNK];
            end
        end
        sum       = {1'b0, a_sl} + {1'b0, ~b_sl} + {{CHUNK{1'b0}}, ~borrow};
        borrow_nx = ~sum[CHUNK];
        diff_nx   = diff;
        for (int i = 0; i < NCH; i++) begin
            if (k == KW'(i)) begin
                diff_nx[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end
    end

    // Control FSM with registered handshake outputs, result and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            neg       <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            k         <= '0;
            borrow    <= 1'b0;
            ra        <= '0;
            rb        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra       <= a;
                        rb       <= b;
                        borrow   <= bin;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    diff   <= diff_nx;
                    borrow <= borrow_nx;
                    k      <= k + KW'(1);
                    if (k == KW'(NCH - 1)) begin
                        bout      <= borrow_nx;
                        neg       <= diff_nx[31];
                        zero      <= (diff_nx == 32'd0);
                        ovf       <= (ra[31] != rb[31]) && (diff_nx[31] != ra[31]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        k         <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
